// File: rtl/alu_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sweep_pkg
//  Description : Shared types, constants and the ALU reference function used
//                by the ALU sweep built-in self-test. The ALU bench may reuse
//                alu_ref() as its golden model.
//  Contents    : alu_op_e       - ALU opcode map (ADD..EQ = 0..7)
//                sweep_state_e  - sweep FSM state encoding
//                NUM_OPS        - number of opcodes swept
//                REF_MAX_W      - widest operand alu_ref() can evaluate
//                alu_ref()      - expected ALU result, masked to 'width' bits
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_sweep_pkg;

    localparam int NUM_OPS   = 8;
    localparam int REF_MAX_W = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SLL = 3'd2,
        OP_SRL = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_EQ  = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } sweep_state_e;

    // Operands arrive zero-extended to REF_MAX_W; the result is masked back
    // to 'width' bits so ADD/SUB wrap modulo 2^width and SLL drops the bits
    // shifted past the top of the real datapath.
    function automatic logic [REF_MAX_W-1:0] alu_ref(
        input logic [REF_MAX_W-1:0] a,
        input logic [REF_MAX_W-1:0] b,
        input alu_op_e              op,
        input int unsigned          width
    );
        logic [REF_MAX_W-1:0] mask;
        logic [REF_MAX_W-1:0] raw;
        mask = '1;
        if (width < REF_MAX_W) begin
            mask = (REF_MAX_W'(1) << width) - REF_MAX_W'(1);
        end
        raw = '0;
        case (op)
            OP_ADD:  raw = a + b;
            OP_SUB:  raw = a - b;
            OP_SLL:  raw = a << b[2:0];
            OP_SRL:  raw = a >> b[2:0];
            OP_AND:  raw = a & b;
            OP_OR:   raw = a | b;
            OP_XOR:  raw = a ^ b;
            OP_EQ:   raw[0] = (a == b);
            default: raw = '0;
        endcase
        return raw & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sweep_bist_ref.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ref_model
//  Description : Combinational reference for the ALU under test. Computes the
//                expected result of (a_i op_i b_i) and flags when the ALU's
//                actual result differs from it.
//  Ports       : a_i, b_i    [DATA_W]  operands currently driven to the ALU
//                op_i        [3]       opcode currently driven to the ALU
//                res_i       [DATA_W]  result returned by the ALU
//                mismatch_o  [1]       1 when res_i != expected result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ref_model
    import alu_sweep_pkg::*;
#(
    parameter int DATA_W = 8   // must not exceed REF_MAX_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] res_i,
    output logic              mismatch_o
);

    logic [REF_MAX_W-1:0] w_ref;

    assign w_ref = alu_ref(REF_MAX_W'(a_i), REF_MAX_W'(b_i), alu_op_e'(op_i), DATA_W);

    // Compare at full reference width: the upper bits of w_ref are always
    // zero, so this is equivalent to a DATA_W-wide compare.
    assign mismatch_o = (w_ref != REF_MAX_W'(res_i));

endmodule
`default_nettype wire

// File: rtl/alu_sweep_bist.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sweep_bist
//  Description : Built-in self-test initiator/checker for the external 8-op
//                combinational ALU. On an accepted start it latches the two
//                operands, drives each opcode 0..7 in turn, waits
//                SETTLE_CYCLES, samples the ALU result and compares it with
//                the internal reference. Reports pass flag, error count and a
//                per-opcode fail mask.
//  Ports       : clk, reset (async, active-high)
//                start_i                 begin a sweep (sampled in IDLE only)
//                a_i, b_i                operands, latched on accepted start
//                alu_a_o, alu_b_o        operands driven to the ALU
//                alu_op_o                opcode driven to the ALU
//                alu_res_i               ALU result
//                busy_o                  accepted start .. done pulse
//                done_o                  one-cycle end-of-sweep pulse
//                pass_o                  err_cnt_o == 0, valid from done
//                err_cnt_o               mismatching opcodes (0..8)
//                fail_mask_o             bit k = opcode k mismatched
//  Options     : `define ALU_SWEEP_CAPTURE_EN adds an 8-entry capture array
//                of ALU results plus ports rd_idx_i / rd_data_o
//                (combinational read).
//  Timing      : SETTLE_CYCLES+2 cycles per opcode; done_o is asserted
//                8*(SETTLE_CYCLES+2)+1 cycles after the start-accept cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sweep_bist
    import alu_sweep_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 1    // 0..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [2:0]        alu_op_o,
    input  logic [DATA_W-1:0] alu_res_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [3:0]        err_cnt_o,
    output logic [7:0]        fail_mask_o
`ifdef ALU_SWEEP_CAPTURE_EN
    ,
    input  logic [2:0]        rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
`endif
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam logic [2:0] LAST_OP     = 3'(NUM_OPS - 1);

    sweep_state_e r_state;
    sweep_state_e w_next_state;
    logic [3:0]   r_settle_cnt;
    logic         w_mismatch;
    logic [3:0]   w_err_next;
    logic [7:0]   w_mask_next;

    // ------------------------------------------------------------------
    // Reference model: always evaluates whatever is currently on the ALU
    // inputs, so its verdict is meaningful in CHECK.
    // ------------------------------------------------------------------
    alu_ref_model #(
        .DATA_W (DATA_W)
    ) u_ref (
        .a_i        (alu_a_o),
        .b_i        (alu_b_o),
        .op_i       (alu_op_o),
        .res_i      (alu_res_i),
        .mismatch_o (w_mismatch)
    );

    assign w_err_next  = err_cnt_o + {3'b000, w_mismatch};
    assign w_mask_next = fail_mask_o | (8'(w_mismatch) << alu_op_o);

    // Status outputs decode straight from the state register; reset forces
    // IDLE so both drop to 0 immediately and no done pulse can follow.
    assign busy_o = (r_state != ST_IDLE);
    assign done_o = (r_state == ST_DONE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_next_state = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (SETTLE_INIT == 4'd0) begin
                    w_next_state = ST_CHECK;
                end else begin
                    w_next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Leaving on the cycle the count decrements to zero keeps
                // SETTLE exactly SETTLE_CYCLES cycles long.
                if (r_settle_cnt <= 4'd1) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (alu_op_o == LAST_OP) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_DRIVE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operands, opcode, settle counter, results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a_o      <= '0;
            alu_b_o      <= '0;
            alu_op_o     <= 3'd0;
            r_settle_cnt <= 4'd0;
            err_cnt_o    <= 4'd0;
            fail_mask_o  <= 8'h00;
            pass_o       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        alu_a_o     <= a_i;
                        alu_b_o     <= b_i;
                        alu_op_o    <= 3'd0;
                        err_cnt_o   <= 4'd0;
                        fail_mask_o <= 8'h00;
                        pass_o      <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    r_settle_cnt <= SETTLE_INIT;
                end
                ST_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt - 4'd1;
                end
                ST_CHECK: begin
                    err_cnt_o   <= w_err_next;
                    fail_mask_o <= w_mask_next;
                    // pass_o is resolved here so it is already valid while
                    // done_o is high. The opcode stops at 7 so the ALU
                    // inputs hold until the next start.
                    if (alu_op_o == LAST_OP) begin
                        pass_o <= (w_err_next == 4'd0);
                    end else begin
                        alu_op_o <= alu_op_o + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_SWEEP_CAPTURE_EN
    // ------------------------------------------------------------------
    // Captured ALU results, one per opcode; survive a new start and are
    // only cleared by reset.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_capture [NUM_OPS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                r_capture[i] <= '0;
            end
        end else if (r_state == ST_CHECK) begin
            r_capture[alu_op_o] <= alu_res_i;
        end
    end

    assign rd_data_o = r_capture[rd_idx_i];
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sweep_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sweep_bist
//  Description : Self-checking bench for alu_sweep_bist. The external ALU is
//                a table-driven stub whose per-opcode outputs are
//                hand-computed constants, so a mismatch against the DUT's
//                internal reference shows up in fail_mask/err_cnt. Expected
//                sweep outcomes are queued when a start is issued; per-DUT
//                monitors pop and compare on every done pulse.
//                Instances: main (SETTLE_CYCLES=1), s0 (=0) and s3 (=3);
//                s0/s3 see an ALU whose output lags its inputs by 3 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sweep_bist;

    // Golden ALU outputs per opcode, opcode 0 in the low byte.
    localparam logic [63:0] T_07_03 = {8'h00, 8'h04, 8'h07, 8'h03, 8'h00, 8'h38, 8'h04, 8'h0A};
    localparam logic [63:0] T_ADDBAD = {8'h00, 8'h04, 8'h07, 8'h03, 8'h00, 8'h38, 8'h04, 8'h00};
    localparam logic [63:0] T_OP3OP6 = {8'h00, 8'h00, 8'h07, 8'h03, 8'hFF, 8'h38, 8'h04, 8'h0A};
    localparam logic [63:0] T_03_07 = {8'h00, 8'h04, 8'h07, 8'h03, 8'h00, 8'h80, 8'hFC, 8'h0A};
    localparam logic [63:0] T_81_09 = {8'h00, 8'h88, 8'h89, 8'h01, 8'h40, 8'h02, 8'h78, 8'h8A};
    localparam logic [63:0] T_55_55 = {8'h01, 8'h00, 8'h55, 8'h55, 8'h02, 8'hA0, 8'h00, 8'hAA};

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] mask;
        logic [3:0] err;
        logic       pass;
        int         start_cyc;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    exp_t q_m[$];
    exp_t q_0[$];
    exp_t q_3[$];
    exp_t e_m, e_0, e_3;

    // ---------------- main instance ----------------
    logic       rst_m, start_m, busy_m, done_m, pass_m;
    logic [7:0] a_m, b_m, alu_a_m, alu_b_m, res_m, mask_m;
    logic [2:0] op_m;
    logic [3:0] err_m;
    logic [63:0] tbl_m;

    assign res_m = tbl_m[{op_m, 3'b000} +: 8];

    // ---------------- s0 / s3 instances (shared stimulus) ----------------
    logic       rst_x, start_x;
    logic [7:0] a_x, b_x;
    logic [63:0] tbl_x = T_07_03;
    logic       busy_0, done_0, pass_0, busy_3, done_3, pass_3;
    logic [7:0] alu_a_0, alu_b_0, mask_0, alu_a_3, alu_b_3, mask_3;
    logic [2:0] op_0, op_3;
    logic [3:0] err_0, err_3;
    logic [7:0] d0_0 = 8'h00, d1_0 = 8'h00, d2_0 = 8'h00;
    logic [7:0] d0_3 = 8'h00, d1_3 = 8'h00, d2_3 = 8'h00;

    // ALU whose output reflects its inputs three clocks earlier.
    always @(posedge clk) begin
        d0_0 <= tbl_x[{op_0, 3'b000} +: 8];
        d1_0 <= d0_0;
        d2_0 <= d1_0;
        d0_3 <= tbl_x[{op_3, 3'b000} +: 8];
        d1_3 <= d0_3;
        d2_3 <= d1_3;
    end

`ifdef ALU_SWEEP_CAPTURE_EN
    logic [2:0] rd_idx;
    logic [7:0] rd_data, rd_data_0, rd_data_3;
`endif

    alu_sweep_bist #(.DATA_W(8), .SETTLE_CYCLES(1)) u_main (
        .clk(clk), .reset(rst_m), .start_i(start_m), .a_i(a_m), .b_i(b_m),
        .alu_a_o(alu_a_m), .alu_b_o(alu_b_m), .alu_op_o(op_m), .alu_res_i(res_m),
        .busy_o(busy_m), .done_o(done_m), .pass_o(pass_m), .err_cnt_o(err_m),
        .fail_mask_o(mask_m)
`ifdef ALU_SWEEP_CAPTURE_EN
        , .rd_idx_i(rd_idx), .rd_data_o(rd_data)
`endif
    );

    alu_sweep_bist #(.DATA_W(8), .SETTLE_CYCLES(0)) u_s0 (
        .clk(clk), .reset(rst_x), .start_i(start_x), .a_i(a_x), .b_i(b_x),
        .alu_a_o(alu_a_0), .alu_b_o(alu_b_0), .alu_op_o(op_0), .alu_res_i(d2_0),
        .busy_o(busy_0), .done_o(done_0), .pass_o(pass_0), .err_cnt_o(err_0),
        .fail_mask_o(mask_0)
`ifdef ALU_SWEEP_CAPTURE_EN
        , .rd_idx_i(3'd0), .rd_data_o(rd_data_0)
`endif
    );

    alu_sweep_bist #(.DATA_W(8), .SETTLE_CYCLES(3)) u_s3 (
        .clk(clk), .reset(rst_x), .start_i(start_x), .a_i(a_x), .b_i(b_x),
        .alu_a_o(alu_a_3), .alu_b_o(alu_b_3), .alu_op_o(op_3), .alu_res_i(d2_3),
        .busy_o(busy_3), .done_o(done_3), .pass_o(pass_3), .err_cnt_o(err_3),
        .fail_mask_o(mask_3)
`ifdef ALU_SWEEP_CAPTURE_EN
        , .rd_idx_i(3'd0), .rd_data_o(rd_data_3)
`endif
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input logic [7:0] mask,
                         input logic [3:0] err, input logic pass, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op);
        check({tag, "_latency"}, 64'(cyc - e.start_cyc), 64'(e.lat));
        check({tag, "_fail_mask"}, 64'(mask), 64'(e.mask));
        check({tag, "_err_cnt"}, 64'(err), 64'(e.err));
        check({tag, "_pass"}, 64'(pass), 64'(e.pass));
        check({tag, "_alu_a_hold"}, 64'(a), 64'(e.a));
        check({tag, "_alu_b_hold"}, 64'(b), 64'(e.b));
        check({tag, "_alu_op_hold"}, 64'(op), 64'd7);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (done_m) begin
            if (q_m.size() == 0) begin
                check("main_unexpected_done", 64'd1, 64'd0);
            end else begin
                e_m = q_m.pop_front();
                score("main", e_m, mask_m, err_m, pass_m, alu_a_m, alu_b_m, op_m);
            end
        end
    end

    always @(negedge clk) begin
        if (done_0) begin
            if (q_0.size() == 0) begin
                check("s0_unexpected_done", 64'd1, 64'd0);
            end else begin
                e_0 = q_0.pop_front();
                score("s0", e_0, mask_0, err_0, pass_0, alu_a_0, alu_b_0, op_0);
            end
        end
    end

    always @(negedge clk) begin
        if (done_3) begin
            if (q_3.size() == 0) begin
                check("s3_unexpected_done", 64'd1, 64'd0);
            end else begin
                e_3 = q_3.pop_front();
                score("s3", e_3, mask_3, err_3, pass_3, alu_a_3, alu_b_3, op_3);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle_m(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_m && n < budget);
        check({name, "_timeout"}, 64'(busy_m), 64'd0);
        @(negedge clk);
    endtask

    task automatic sweep_m(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [63:0] tbl, input logic [7:0] mask, input logic [3:0] err);
        exp_t e;
        tbl_m = tbl;
        a_m = a;
        b_m = b;
        e.a = a; e.b = b; e.mask = mask; e.err = err; e.pass = (err == 4'd0);
        e.start_cyc = cyc; e.lat = 25;
        q_m.push_back(e);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        wait_idle_m(name, 60);
    endtask

    initial begin
        exp_t ex;
        int   n;
        rst_m = 1'b1; rst_x = 1'b1; start_m = 1'b0; start_x = 1'b0;
        a_m = 8'h00; b_m = 8'h00; a_x = 8'h00; b_x = 8'h00; tbl_m = T_07_03;
`ifdef ALU_SWEEP_CAPTURE_EN
        rd_idx = 3'd0;
`endif
        repeat (4) @(negedge clk);
        check("reset_main", {30'd0, busy_m, done_m, pass_m, err_m, mask_m, alu_a_m, alu_b_m, op_m}, 64'd0);
        check("reset_s0", {30'd0, busy_0, done_0, pass_0, err_0, mask_0, alu_a_0, alu_b_0, op_0}, 64'd0);
        check("reset_s3", {30'd0, busy_3, done_3, pass_3, err_3, mask_3, alu_a_3, alu_b_3, op_3}, 64'd0);
        rst_m = 1'b0;
        rst_x = 1'b0;
        repeat (4) @(negedge clk);

        sweep_m("golden_07_03", 8'h07, 8'h03, T_07_03, 8'h00, 4'd0);
`ifdef ALU_SWEEP_CAPTURE_EN
        for (int k = 0; k < 8; k++) begin
            rd_idx = 3'(k);
            #1;
            check("capture_entry", {56'd0, rd_data}, {56'd0, T_07_03[8*k +: 8]});
        end
`endif
        sweep_m("bad_add", 8'h07, 8'h03, T_ADDBAD, 8'h01, 4'd1);
        sweep_m("bad_op3_op6", 8'h07, 8'h03, T_OP3OP6, 8'h48, 4'd2);
        sweep_m("sub_wrap_03_07", 8'h03, 8'h07, T_03_07, 8'h00, 4'd0);
        sweep_m("shift_81_09", 8'h81, 8'h09, T_81_09, 8'h00, 4'd0);
        sweep_m("eq_55_55", 8'h55, 8'h55, T_55_55, 8'h00, 4'd0);

        // Second start mid-sweep with other operands must be ignored.
        tbl_m = T_07_03;
        a_m = 8'h07; b_m = 8'h03;
        ex.a = 8'h07; ex.b = 8'h03; ex.mask = 8'h00; ex.err = 4'd0; ex.pass = 1'b1;
        ex.start_cyc = cyc; ex.lat = 25;
        q_m.push_back(ex);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (9) @(negedge clk);
        a_m = 8'hFF; b_m = 8'hFF; start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        wait_idle_m("ignored_start", 60);
        repeat (10) @(negedge clk);

        // Reset 12 cycles into a failing sweep: outputs clear at once and
        // no done pulse follows.
        tbl_m = T_ADDBAD;
        a_m = 8'h07; b_m = 8'h03;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_abort_busy", 64'(busy_m), 64'd1);
        rst_m = 1'b1;
        #1;
        check("abort_outputs", {30'd0, busy_m, done_m, pass_m, err_m, mask_m, alu_a_m, alu_b_m, op_m}, 64'd0);
        @(negedge clk);
        rst_m = 1'b0;
        repeat (30) @(negedge clk);
        sweep_m("after_abort", 8'h07, 8'h03, T_07_03, 8'h00, 4'd0);

        // Delayed ALU: SETTLE_CYCLES=0 samples stale data on opcodes 1..7,
        // SETTLE_CYCLES=3 waits long enough.
        a_x = 8'h07; b_x = 8'h03;
        ex.a = 8'h07; ex.b = 8'h03; ex.start_cyc = cyc;
        ex.mask = 8'hFE; ex.err = 4'd7; ex.pass = 1'b0; ex.lat = 17;
        q_0.push_back(ex);
        ex.mask = 8'h00; ex.err = 4'd0; ex.pass = 1'b1; ex.lat = 41;
        q_3.push_back(ex);
        start_x = 1'b1;
        @(negedge clk);
        start_x = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy_0 || busy_3) && n < 100);
        check("settle_sweeps_timeout", {62'd0, busy_0, busy_3}, 64'd0);
        repeat (3) @(negedge clk);

        check("queues_drained", 64'(q_m.size() + q_0.size() + q_3.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
